// File: rtl/adaptive_step_ctrl.sv
// Adaptive step-size controller: reduces |x_lo - x_hi| to an error, then rescales the step by SAFETY*clamp(tol/err).
// Define STEP_MAX_NORM_EN for an infinity-norm error; the default build uses a saturating L1 norm.
module adaptive_step_ctrl #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned FRAC_BITS     = 7,
    parameter int unsigned SAFETY        = 115,
    parameter int unsigned MIN_SCALE     = 32,
    parameter int unsigned MAX_SCALE     = 512,
    parameter int unsigned MAX_RETRIES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init,
    input  logic                     start,
    input  logic                     read_step,
    input  logic [WORD_SIZE-1:0]     step_in,
    input  logic [ADDRESS_WIDTH-1:0] x0_address,
    input  logic [ADDRESS_WIDTH-1:0] x1_address,
    input  logic [WORD_SIZE-1:0]     memory_data1,
    input  logic [WORD_SIZE-1:0]     memory_data2,
    output logic [ADDRESS_WIDTH-1:0] memory_address1,
    output logic [ADDRESS_WIDTH-1:0] memory_address2,
    output logic [WORD_SIZE-1:0]     step_out,
    output logic                     done,
    output logic                     proceed,
    output logic                     error_failure,
    output logic                     busy
);

    localparam int unsigned QW = WORD_SIZE + FRAC_BITS;
    localparam int unsigned CW = $clog2(QW + 1);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
    localparam int unsigned PW = 2 * WORD_SIZE + QW;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_INIT_A = 4'd1;
    localparam logic [3:0] S_INIT_B = 4'd2;
    localparam logic [3:0] S_INIT_C = 4'd3;
    localparam logic [3:0] S_ACC    = 4'd4;
    localparam logic [3:0] S_EVAL   = 4'd5;
    localparam logic [3:0] S_DIV    = 4'd6;
    localparam logic [3:0] S_SCALE  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]               r_state, w_state_nxt;
    logic [WORD_SIZE-1:0]     r_n, r_tol, r_step, r_err, r_idx, r_rem;
    logic [QW-1:0]            r_quo;
    logic [CW-1:0]            r_cnt;
    logic [RW-1:0]            r_retry;
    logic                     r_accept, r_proceed, r_fail, r_done, r_busy;
    logic [ADDRESS_WIDTH-1:0] r_addr1, r_addr2;

    logic [WORD_SIZE-1:0]     w_idx_nxt, w_d, w_acc_nxt, w_rem_nxt, w_s;
    logic [ADDRESS_WIDTH-1:0] w_addr1_nxt, w_addr2_nxt;
    logic [WORD_SIZE:0]       w_rem_sh;
    logic                     w_ge, w_limit;
    logic [QW-1:0]            w_quo_nxt, w_scale;
    logic [PW-1:0]            w_prod, w_shift;
    logic [RW-1:0]            w_retry_inc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, element index and next-cycle memory addresses
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = '0;
        w_addr1_nxt = '0;
        w_addr2_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (init)           w_state_nxt = S_INIT_A;
                else if (read_step) w_state_nxt = S_IDLE;
                else if (start)     w_state_nxt = S_ACC;
            end
            S_INIT_A: w_state_nxt = S_INIT_B;
            S_INIT_B: w_state_nxt = S_INIT_C;
            S_INIT_C: w_state_nxt = S_IDLE;
            S_ACC: begin
                w_idx_nxt = r_idx + WORD_SIZE'(1);
                if (r_idx == r_n) w_state_nxt = S_EVAL;
            end
            S_EVAL:   w_state_nxt = (r_err == '0) ? S_SCALE : S_DIV;
            S_DIV:    if (r_cnt == CW'(QW - 1)) w_state_nxt = S_SCALE;
            S_SCALE:  w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        case (w_state_nxt)
            S_INIT_A: w_addr2_nxt = ADDRESS_WIDTH'(1);
            S_INIT_B: w_addr1_nxt = ADDRESS_WIDTH'(2);
            S_ACC: begin
                if (w_idx_nxt < r_n) begin
                    w_addr1_nxt = x0_address + ADDRESS_WIDTH'(w_idx_nxt);
                    w_addr2_nxt = x1_address + ADDRESS_WIDTH'(w_idx_nxt);
                end
            end
            default: ;
        endcase
    end

    assign w_d = (memory_data1 >= memory_data2) ? (memory_data1 - memory_data2)
                                                : (memory_data2 - memory_data1);
`ifdef STEP_MAX_NORM_EN
    assign w_acc_nxt = (w_d > r_err) ? w_d : r_err;
`else
    logic [WORD_SIZE:0] w_sum;
    assign w_sum     = {1'b0, r_err} + {1'b0, w_d};
    assign w_acc_nxt = w_sum[WORD_SIZE] ? '1 : w_sum[WORD_SIZE-1:0];
`endif

    // One restoring-division iteration; dividend bits shift out of the quotient register
    assign w_rem_sh  = {r_rem, r_quo[QW-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_err});
    assign w_rem_nxt = w_ge ? WORD_SIZE'(w_rem_sh - {1'b0, r_err}) : WORD_SIZE'(w_rem_sh);
    assign w_quo_nxt = {r_quo[QW-2:0], w_ge};

    assign w_scale = (r_quo < QW'(MIN_SCALE)) ? QW'(MIN_SCALE) :
                     (r_quo > QW'(MAX_SCALE)) ? QW'(MAX_SCALE) : r_quo;
    assign w_prod  = PW'(r_step) * PW'(SAFETY) * PW'(w_scale);
    assign w_shift = w_prod >> (2 * FRAC_BITS);
    assign w_s     = (|w_shift[PW-1:WORD_SIZE]) ? '1 :
                     (w_shift[WORD_SIZE-1:0] == '0) ? WORD_SIZE'(1) : w_shift[WORD_SIZE-1:0];

    assign w_retry_inc = (r_retry >= RW'(MAX_RETRIES)) ? r_retry : (r_retry + RW'(1));
    assign w_limit     = (w_retry_inc == RW'(MAX_RETRIES));

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n       <= '0;
            r_tol     <= '0;
            r_step    <= '0;
            r_err     <= '0;
            r_idx     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_accept  <= 1'b0;
            r_proceed <= 1'b0;
            r_fail    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_addr1   <= '0;
            r_addr2   <= '0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_addr1 <= w_addr1_nxt;
            r_addr2 <= w_addr2_nxt;
            r_done  <= (w_state_nxt == S_DONE);
            r_busy  <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (!init && read_step)    r_step <= step_in;
                    if (w_state_nxt == S_ACC)  r_err  <= '0;
                end
                S_INIT_B: begin
                    r_n   <= memory_data1;
                    r_tol <= memory_data2;
                end
                S_INIT_C: begin
                    r_step    <= memory_data1;
                    r_retry   <= '0;
                    r_fail    <= 1'b0;
                    r_proceed <= 1'b0;
                end
                S_ACC: if (r_idx != '0) r_err <= w_acc_nxt;
                S_EVAL: begin
                    r_accept <= (r_err <= r_tol);
                    r_rem    <= '0;
                    r_cnt    <= '0;
                    r_quo    <= (r_err == '0) ? QW'(MAX_SCALE) : {r_tol, {FRAC_BITS{1'b0}}};
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_SCALE: begin
                    if (r_accept) begin
                        r_step    <= w_s;
                        r_proceed <= 1'b1;
                        r_retry   <= '0;
                    end else begin
                        r_proceed <= 1'b0;
                        r_retry   <= w_retry_inc;
                        if (w_limit) r_fail <= 1'b1;
                        else         r_step <= w_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign memory_address1 = r_addr1;
    assign memory_address2 = r_addr2;
    assign step_out        = r_step;
    assign done            = r_done;
    assign proceed         = r_proceed;
    assign error_failure   = r_fail;
    assign busy            = r_busy;

endmodule

// File: tb/tb_adaptive_step_ctrl.sv
// Directed bench for adaptive_step_ctrl with a scoreboard of predicted attempt outcomes.
module tb_adaptive_step_ctrl;

    logic        clk = 1'b0;
    logic        rst, init, start, read_step;
    logic [15:0] step_in, x0, x1, md1, md2, a1, a2, step_out;
    logic        done, proceed, error_failure, busy;

    logic [15:0] mem [0:255];
    int          m_d [16];
    int          m_n, m_tol, m_step, m_retry;
    logic        m_prc, m_fail;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct {
        int          lat;
        logic        prc;
        logic [15:0] stp;
        logic        fail;
    } exp_t;
    exp_t sbq[$];

    adaptive_step_ctrl dut (
        .clk(clk), .rst(rst), .init(init), .start(start), .read_step(read_step),
        .step_in(step_in), .x0_address(x0), .x1_address(x1),
        .memory_data1(md1), .memory_data2(md2),
        .memory_address1(a1), .memory_address2(a2),
        .step_out(step_out), .done(done), .proceed(proceed),
        .error_failure(error_failure), .busy(busy)
    );

    always #5 clk = ~clk;

    // Two synchronous read ports
    always @(posedge clk) begin
        md1 <= mem[a1[7:0]];
        md2 <= mem[a2[7:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_diffs(input int d, input int inc);
        for (int i = 0; i < 16; i++) begin
            int v;
            v = d + i * inc;
            m_d[i] = v;
            if (i % 2 == 1) begin
                mem[16+i] = 16'(1000 + i);
                mem[32+i] = 16'(1000 + i + v);
            end else begin
                mem[16+i] = 16'(1000 + i + v);
                mem[32+i] = 16'(1000 + i);
            end
        end
    endtask

    // Reference outcome of one attempt, pushed to the scoreboard
    task automatic predict();
        int    err;
        longint q, sc, s;
        logic  acc;
        err = 0;
        for (int i = 0; i < m_n; i++) begin
`ifdef STEP_MAX_NORM_EN
            if (m_d[i] > err) err = m_d[i];
`else
            err = err + m_d[i];
            if (err > 65535) err = 65535;
`endif
        end
        if (err == 0) sc = 512;
        else begin
            q  = (longint'(m_tol) * 128) / longint'(err);
            sc = (q < 32) ? 32 : ((q > 512) ? 512 : q);
        end
        s = (longint'(m_step) * 115 * sc) >> 14;
        if (s > 65535) s = 65535;
        if (s == 0) s = 1;
        acc = (err <= m_tol);
        if (acc) begin
            m_step  = int'(s);
            m_prc   = 1'b1;
            m_retry = 0;
        end else begin
            m_prc = 1'b0;
            if (m_retry < 4) m_retry++;
            if (m_retry == 4) m_fail = 1'b1;
            else              m_step = int'(s);
        end
        sbq.push_back('{lat: m_n + 4 + ((err == 0) ? 0 : 23), prc: m_prc, stp: 16'(m_step), fail: m_fail});
    endtask

    task automatic do_init();
        m_n = int'(mem[0]); m_tol = int'(mem[1]); m_step = int'(mem[2]);
        m_retry = 0; m_fail = 1'b0; m_prc = 1'b0;
        @(negedge clk) init = 1'b1;
        @(negedge clk) init = 1'b0;
        check("init_busy_c1", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        check("init_busy_c3", 32'(busy), 32'd1);
        @(negedge clk);
        check("init_busy_c4", 32'(busy), 32'd0);
        check("init_step", 32'(step_out), 32'(m_step));
        check("init_proceed", 32'(proceed), 32'd0);
        check("init_fail", 32'(error_failure), 32'd0);
    endtask

    task automatic do_read_step(input int v, input bit with_start);
        @(negedge clk) begin read_step = 1'b1; start = with_start; step_in = 16'(v); end
        @(negedge clk) begin read_step = 1'b0; start = 1'b0; end
        m_step = v;
        check("rdstep_step", 32'(step_out), 32'(v));
        check("rdstep_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rdstep_busy2", 32'(busy), 32'd0);
    endtask

    task automatic run_attempt(input string tag, input bit poke);
        exp_t e;
        int   cyc;
        predict();
        if (poke) step_in = 16'd999;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        if (m_n > 0) begin
            check({tag, "_addr1"}, 32'(a1), 32'd16);
            check({tag, "_addr2"}, 32'(a2), 32'd32);
        end
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start     = poke && (cyc == 5);
            read_step = start;
            init      = start;
        end
        e = sbq.pop_front();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        check({tag, "_proceed"}, 32'(proceed), 32'(e.prc));
        check({tag, "_step"}, 32'(step_out), 32'(e.stp));
        check({tag, "_fail"}, 32'(error_failure), 32'(e.fail));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_addr"}, 32'({a1, a2}), 32'd0);
    endtask

    initial begin
        int dn;
        rst = 1'b1; init = 1'b0; start = 1'b0; read_step = 1'b0;
        step_in = '0; x0 = 16'd16; x1 = 16'd32;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_step", 32'(step_out), 32'd0);
        check("rst_flags", 32'({done, proceed, error_failure, busy}), 32'd0);
        check("rst_addr", 32'({a1, a2}), 32'd0);
        rst = 1'b0;

        mem[0] = 16'd4; mem[1] = 16'd64; mem[2] = 16'd128;
        set_diffs(8, 0);
        do_init();
        run_attempt("accept", 1'b1);
        set_diffs(3, 5);
        run_attempt("accept_var", 1'b0);

        do_read_step(128, 1'b1);
        set_diffs(64, 0);
        run_attempt("reject", 1'b0);
        set_diffs(200, 0);
        run_attempt("retry2", 1'b0);
        run_attempt("retry3", 1'b0);
        run_attempt("retry4", 1'b0);

        do_init();
        set_diffs(0, 0);
        run_attempt("zero_err", 1'b0);
        do_read_step(60000, 1'b0);
        run_attempt("saturate", 1'b0);

        mem[0] = 16'd0;
        do_init();
        run_attempt("n_zero", 1'b0);

        mem[0] = 16'd4;
        set_diffs(8, 0);
        do_init();
        run_attempt("pre_rst", 1'b0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_step", 32'(step_out), 32'd0);
        check("midrst_flags", 32'({done, proceed, error_failure, busy}), 32'd0);
        check("midrst_addr", 32'({a1, a2}), 32'd0);
        @(negedge clk) rst = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("midrst_no_done", 32'(dn), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        do_init();
        run_attempt("recover", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
